// File: rtl/pmux_pkg.sv
// Shared helpers for the pmux pipeline: select-width derivation and the single 2:1 XOR/AND mux cell.
// The cell is defined once on a 1-bit lane; every datapath bit instantiates this same equation.
package pmux_pkg;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Select width is derived from NUM only; a single candidate still carries one select bit.
  function automatic int selw_f(input int num);
    return (num < 2) ? 1 : clog2_f(num);
  endfunction

  function automatic logic mux2_f(input logic a, input logic b, input logic s);
    return ((a ^ b) & s) ^ a;
  endfunction

endpackage

// File: rtl/pmux_pipe_if.sv
// Handshake bundle for pmux_pipe: candidate set + select in, selected word out.
// master drives the candidates and OUT_READY; slave is the selector.
interface pmux_pipe_if import pmux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NUM   = 8
);
  localparam int SELW = selw_f(NUM);

  logic                  in_valid;
  logic                  in_ready;
  logic [NUM*WIDTH-1:0]  in_data;
  logic [SELW-1:0]       in_sel;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pmux_level.sv
// One registered halving of the candidate set on select bit 0; 1-cycle latency.
// Forwards valid and the upper select bits; on stall every register holds, bubbles included.
module pmux_level import pmux_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int IN_NUM = 2,
  parameter int SW     = 1,
  localparam int SO    = (SW > 1) ? SW - 1 : 1,
  localparam int OUT_W = (IN_NUM / 2) * WIDTH
) (
  input  logic                    clk,
  input  logic                    srst_n,
  input  logic                    stall,
  input  logic                    in_vld,
  input  logic [IN_NUM*WIDTH-1:0] in_dat,
  input  logic [SW-1:0]           in_sel,
  output logic                    out_vld,
  output logic [OUT_W-1:0]        out_dat,
  output logic [SO-1:0]           out_sel
);
  logic [OUT_W-1:0] mux_dat;

  // Pair j: A = word 2j, B = word 2j+1, S = lowest remaining select bit.
  for (genvar j = 0; j < IN_NUM / 2; j++) begin : g_pair
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      assign mux_dat[j*WIDTH+b] = mux2_f(in_dat[2*j*WIDTH+b], in_dat[(2*j+1)*WIDTH+b], in_sel[0]);
    end
  end

  logic             vld_q, vld_d;
  logic [OUT_W-1:0] dat_q, dat_d;
  logic [SO-1:0]    sel_q, sel_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    sel_d = sel_q;
    if (!stall) begin
      vld_d = in_vld;
      dat_d = mux_dat;
      sel_d = SO'(in_sel >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      sel_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
    end
  end

  assign out_vld = vld_q;
  assign out_dat = dat_q;
  assign out_sel = sel_q;
endmodule

// File: rtl/pmux_pipe.sv
// Pipelined N:1 selector from XOR/AND mux cells, SELW-cycle latency, full throughput; any stall freezes all levels.
// PMUX_PIPE_SKID_EN adds a 2-entry output skid (latency SELW+1) and makes IN_READY a register.
module pmux_pipe import pmux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NUM   = 8
) (
  input logic        CLK,
  input logic        SRST_N,
  pmux_pipe_if.slave bus
);
  localparam int SELW = selw_f(NUM);

  logic stall;

  for (genvar l = 0; l < SELW; l++) begin : g_lvl
    localparam int IN_N = NUM >> l;
    localparam int SW   = SELW - l;
    localparam int SO   = (SW > 1) ? SW - 1 : 1;

    logic                        vld_i;
    logic [IN_N*WIDTH-1:0]       dat_i;
    logic [SW-1:0]               sel_i;
    logic                        vld_o;
    logic [(IN_N/2)*WIDTH-1:0]   dat_o;
    logic [SO-1:0]               sel_o;

    if (l == 0) begin : g_src
      assign vld_i = bus.in_valid;
      assign dat_i = bus.in_data;
      assign sel_i = bus.in_sel;
    end else begin : g_chain
      assign vld_i = g_lvl[l-1].vld_o;
      assign dat_i = g_lvl[l-1].dat_o;
      assign sel_i = g_lvl[l-1].sel_o;
    end

    pmux_level #(
      .WIDTH  (WIDTH),
      .IN_NUM (IN_N),
      .SW     (SW)
    ) u_level (
      .clk     (CLK),
      .srst_n  (SRST_N),
      .stall   (stall),
      .in_vld  (vld_i),
      .in_dat  (dat_i),
      .in_sel  (sel_i),
      .out_vld (vld_o),
      .out_dat (dat_o),
      .out_sel (sel_o)
    );
  end

  logic             last_vld;
  logic [WIDTH-1:0] last_dat;
  logic             unused_sel;

  assign last_vld   = g_lvl[SELW-1].vld_o;
  assign last_dat   = g_lvl[SELW-1].dat_o;
  assign unused_sel = ^g_lvl[SELW-1].sel_o;

`ifdef PMUX_PIPE_SKID_EN
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic             rdy_q, rdy_d;
  logic             push, pop;

  // The pipe only advances while the skid had room at the last edge, so a push never overflows it.
  assign stall = ~rdy_q;
  assign push  = last_vld & rdy_q;
  assign pop   = (cnt_q != 2'd0) & bus.out_ready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (pop) ent0_d = ent1_q;
    if (push) begin
      if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) ent0_d = last_dat;
      else                                             ent1_d = last_dat;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      cnt_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      rdy_q  <= rdy_d;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = ent0_q;
`else
  assign stall         = last_vld & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = last_vld;
  assign bus.out_data  = last_dat;
`endif
endmodule

// File: tb/tb_pmux_pipe.sv
// Scoreboarded bench for pmux_pipe: directed NUM=8 vectors plus random NUM=4/NUM=16 streams.
`timescale 1ns/1ps
module tb_pmux_pipe;
  localparam int W = 8;
`ifdef PMUX_PIPE_SKID_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic CLK = 1'b0;
  logic SRST_N = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  pmux_pipe_if #(.WIDTH(W), .NUM(8))  b8 ();
  pmux_pipe_if #(.WIDTH(W), .NUM(4))  b4 ();
  pmux_pipe_if #(.WIDTH(W), .NUM(16)) b16 ();

  pmux_pipe #(.WIDTH(W), .NUM(8))  dut8  (.CLK(CLK), .SRST_N(SRST_N), .bus(b8.slave));
  pmux_pipe #(.WIDTH(W), .NUM(4))  dut4  (.CLK(CLK), .SRST_N(SRST_N), .bus(b4.slave));
  pmux_pipe #(.WIDTH(W), .NUM(16)) dut16 (.CLK(CLK), .SRST_N(SRST_N), .bus(b16.slave));

  logic [7:0] q8[$];
  logic [7:0] q4[$];
  logic [7:0] q16[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  bit         hold8 = 0;
  logic [7:0] hold_dat;
  int         pops8 = 0, first_pop = -1, last_pop = -1;
  int         pops4 = 0, pops16 = 0;

  always @(negedge CLK) begin
    if (SRST_N) begin
      if (hold8 && b8.out_valid) chk("out8_hold_stable", b8.out_data, hold_dat);
`ifndef PMUX_PIPE_SKID_EN
      if (b8.out_valid && !b8.out_ready) chk("in8_ready_low_on_stall", b8.in_ready, 0);
`endif
      hold8    = b8.out_valid && !b8.out_ready;
      hold_dat = b8.out_data;
      if (b8.out_valid && b8.out_ready) begin
        if (q8.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL out8_unexpected: got %0h, expected no output", b8.out_data);
        end else chk("out8_data", b8.out_data, q8.pop_front());
        pops8++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end else hold8 = 0;
  end

  always @(negedge CLK) begin
    if (SRST_N && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL out4_unexpected: got %0h, expected no output", b4.out_data);
      end else chk("out4_data", b4.out_data, q4.pop_front());
      pops4++;
    end
    if (SRST_N && b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL out16_unexpected: got %0h, expected no output", b16.out_data);
      end else chk("out16_data", b16.out_data, q16.pop_front());
      pops16++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push8(input logic [63:0] dat, input logic [2:0] sel, input logic [7:0] exp, input bit track);
    bit ok;
    b8.in_valid = 1'b1;
    b8.in_data  = dat;
    b8.in_sel   = sel;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK); ok = b8.in_ready;
      @(posedge CLK); #1;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL push8_timeout: got in_ready=0, expected accept within 200 cycles");
    end else if (track) q8.push_back(exp);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300 && (q8.size() + q4.size() + q16.size()) != 0; i++) @(posedge CLK);
    #1;
    chk(nm, q8.size() + q4.size() + q16.size(), 0);
  endtask

  logic [63:0] dat10;
  logic [63:0] datab;
  int          n, p0;
  bit          rnd_on = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end within 50000 cycles");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 8; k++) dat10[k*8 +: 8] = 8'h10 + 8'(k);
    datab = {48'h0, 8'h5A, 8'hA5};
    b8.in_valid = 0;  b8.in_data = '0;  b8.in_sel = '0;  b8.out_ready = 1;
    b4.in_valid = 0;  b4.in_data = '0;  b4.in_sel = '0;  b4.out_ready = 1;
    b16.in_valid = 0; b16.in_data = '0; b16.in_sel = '0; b16.out_ready = 1;

    // Reset state
    repeat (3) @(posedge CLK);
    #1 SRST_N = 1'b1;
    @(negedge CLK);
    chk("rst_out_valid8", b8.out_valid, 0);
    chk("rst_out_data8", b8.out_data, 0);
    chk("rst_in_ready8", b8.in_ready, 1);
    chk("rst_out_valid4", b4.out_valid, 0);
    chk("rst_in_ready16", b16.in_ready, 1);
    @(posedge CLK); #1;

    // Single push, latency measured in cycles from the accept cycle
    push8(dat10, 3'd5, 8'h15, 1);
    b8.in_valid = 0;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (b8.out_valid) break;
      n++;
      @(posedge CLK);
    end
    chk("latency", n, LAT);
    drain("single_drain");
    repeat (3) @(posedge CLK); #1;

    // Back-to-back stream, must come out gapless
    p0 = pops8; first_pop = -1;
    for (int k = 0; k < 8; k++) push8(dat10, 3'(k), 8'h10 + 8'(k), 1);
    b8.in_valid = 0;
    drain("stream_drain");
    chk("stream_count", pops8 - p0, 8);
    chk("stream_gapless", last_pop - first_pop, 7);
    repeat (3) @(posedge CLK); #1;

    // Backpressure window during a stream
    p0 = pops8;
    fork
      begin
        for (int k = 0; k < 8; k++) push8(dat10, 3'((k * 3) % 8), 8'h10 + 8'((k * 3) % 8), 1);
        b8.in_valid = 0;
      end
      begin
        repeat (4) @(posedge CLK);
        #1 b8.out_ready = 0;
        repeat (6) @(posedge CLK);
        #1 b8.out_ready = 1;
      end
    join
    drain("bp_drain");
    chk("bp_count", pops8 - p0, 8);
    repeat (3) @(posedge CLK); #1;

    // Bit-level cell equation with complementary patterns
    push8(datab, 3'd0, 8'hA5, 1);
    push8(datab, 3'd1, 8'h5A, 1);
    b8.in_valid = 0;
    drain("bit_drain");
    repeat (3) @(posedge CLK); #1;

    // Reset with three words in flight: none may ever emerge
    b8.out_ready = 0;
    push8(dat10, 3'd1, 8'h11, 0);
    push8(dat10, 3'd2, 8'h12, 0);
    push8(dat10, 3'd3, 8'h13, 0);
    b8.in_valid = 0;
    SRST_N = 1'b0;
    @(posedge CLK); #1 SRST_N = 1'b1;
    @(negedge CLK);
    chk("midrst_out_valid", b8.out_valid, 0);
    chk("midrst_out_data", b8.out_data, 0);
    chk("midrst_in_ready", b8.in_ready, 1);
    @(posedge CLK); #1 b8.out_ready = 1;
    repeat (8) @(posedge CLK); #1;
    push8(dat10, 3'd6, 8'h16, 1);
    b8.in_valid = 0;
    drain("midrst_drain");

    // Random streams on NUM=4 and NUM=16 against the slice model
    p0 = pops4; n = pops16;
    rnd_on = 1;
    fork
      while (rnd_on) begin
        @(posedge CLK); #1;
        if (rnd_on) begin
          b4.out_ready  = 1'($urandom_range(0, 1));
          b16.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    fork
      for (int k = 0; k < 40; k++) begin
        logic [31:0] d;
        logic [1:0]  s;
        bit          ok;
        d = $urandom; s = 2'($urandom_range(0, 3));
        b4.in_valid = 1; b4.in_data = d; b4.in_sel = s; ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
          @(negedge CLK); ok = b4.in_ready;
          @(posedge CLK); #1;
        end
        if (ok) q4.push_back(d[s*8 +: 8]);
        else begin
          n_chk++; n_fail++;
          $display("FAIL push4_timeout: got in_ready=0, expected accept within 200 cycles");
        end
        b4.in_valid = 0;
        if ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
      end
      for (int k = 0; k < 40; k++) begin
        logic [127:0] d;
        logic [3:0]   s;
        bit           ok;
        d = {$urandom, $urandom, $urandom, $urandom}; s = 4'($urandom_range(0, 15));
        b16.in_valid = 1; b16.in_data = d; b16.in_sel = s; ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
          @(negedge CLK); ok = b16.in_ready;
          @(posedge CLK); #1;
        end
        if (ok) q16.push_back(d[s*8 +: 8]);
        else begin
          n_chk++; n_fail++;
          $display("FAIL push16_timeout: got in_ready=0, expected accept within 200 cycles");
        end
        b16.in_valid = 0;
        if ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
      end
    join
    rnd_on = 0;
    b4.out_ready = 1; b16.out_ready = 1;
    drain("rnd_drain");
    chk("rnd4_count", pops4 - p0, 40);
    chk("rnd16_count", pops16 - n, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
